// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} arb_owner_t;
    localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first winner selection with a saturating fetch starvation counter.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic arb_en,
    output logic win_instr,
    output logic win_data
);
    logic [STARVE_W-1:0] cnt_q, cnt_d;

    assign win_instr = arb_en && i_req && (!d_req || cnt_q >= STARVE_W'(MAX_STARVE));
    assign win_data  = arb_en && d_req && !win_instr;

    // Count only arbitrations fetch actually lost; saturate at all ones.
    always_comb
        cnt_d = win_instr ? '0 :
                (win_data && i_req && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and load/store ports,
// one outstanding transaction at a time, responses routed to the owning requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);
    arb_state_t state_q;
    arb_owner_t owner_q;
    logic       win_i, win_d, resp;

    mem_arb_prio #(.MAX_STARVE(MAX_STARVE)) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .d_req    (d_req),
        .arb_en   (rst_n && state_q == IDLE),
        .win_instr(win_i),
        .win_data (win_d)
    );

    // m_rvalid outside BUSY is spurious and never reaches a requester.
    assign resp     = rst_n && state_q == BUSY && m_rvalid;
    assign i_gnt    = win_i;
    assign d_gnt    = win_d;
    assign m_req    = win_i || win_d;
    assign m_we     = win_d && d_we;
    assign m_addr   = win_i ? i_addr : d_addr;
    assign m_wdata  = win_d ? d_wdata : '0;
    assign m_be     = win_i ? '1 : d_be;
    assign i_rvalid = resp && owner_q == OWN_INSTR;
    assign d_rvalid = resp && owner_q == OWN_DATA;
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end else if (state_q == IDLE && m_req) begin
            state_q <= BUSY;
            owner_q <= win_i ? OWN_INSTR : OWN_DATA;
        end else if (resp) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_be;
    logic        m_req, m_we, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit exp_i, exp_d;
        bit ipend, dpend, busy, own_i;
        int lat, gnt_i, gnt_d, rv_i, rv_d;
        logic [31:0] ia, da, dw;
        bit dwe;

        // reset: outputs quiet even with requests and a response present
        rst_n = 0; idle_inputs();
        step(); i_req = 1; d_req = 1; m_rvalid = 1; #1;
        chk("rst_i_gnt", i_gnt, 0); chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_req", m_req, 0); chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        step(); idle_inputs();
        step(); rst_n = 1;

        // fetch only
        i_req = 1; i_addr = 32'h10; #1;
        chk("f_i_gnt", i_gnt, 1); chk("f_d_gnt", d_gnt, 0); chk("f_m_req", m_req, 1);
        chk("f_m_addr", m_addr, 32'h10); chk("f_m_we", m_we, 0);
        chk("f_m_be", m_be, 4'hf); chk("f_m_wdata", m_wdata, 0);
        step(); i_req = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
        chk("f_i_rvalid", i_rvalid, 1); chk("f_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f_d_rvalid", d_rvalid, 0); chk("f_m_req_rsp", m_req, 0);
        step(); idle_inputs();

        // store with two-cycle memory latency
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678; d_be = 4'b0011; #1;
        chk("s_d_gnt", d_gnt, 1); chk("s_i_gnt", i_gnt, 0); chk("s_m_we", m_we, 1);
        chk("s_m_addr", m_addr, 32'h100); chk("s_m_wdata", m_wdata, 32'h12345678);
        chk("s_m_be", m_be, 4'b0011);
        step(); idle_inputs(); #1;
        chk("s_wait_m_req", m_req, 0); chk("s_wait_rvalid", d_rvalid, 0);
        step(); m_rvalid = 1; #1;
        chk("s_d_rvalid", d_rvalid, 1); chk("s_i_rvalid", i_rvalid, 0); chk("s_m_req_rsp", m_req, 0);
        step(); idle_inputs(); #1;
        chk("s_d_rvalid_done", d_rvalid, 0);

        // simultaneous: data first, then fetch in the next idle cycle
        i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h200; #1;
        chk("c_d_gnt", d_gnt, 1); chk("c_i_gnt", i_gnt, 0); chk("c_m_addr", m_addr, 32'h200);
        step(); d_req = 0; m_rvalid = 1; #1;
        chk("c_d_rvalid", d_rvalid, 1); chk("c_no_gnt_rsp", i_gnt, 0);
        step(); m_rvalid = 0; #1;
        chk("c_i_gnt", i_gnt, 1); chk("c_m_addr_i", m_addr, 32'h20);
        step(); i_req = 0; m_rvalid = 1; #1;
        chk("c_i_rvalid", i_rvalid, 1);
        step(); idle_inputs();

        // starvation with both held and 1-cycle memory
        cnt = 0;
        for (int g = 0; g < 10; g++) begin
            i_req = 1; d_req = 1; m_rvalid = 0; #1;
            exp_i = (cnt >= 4);
            chk("st_cnt", 32'(dut.u_prio.cnt_q), cnt);
            chk("st_i_gnt", i_gnt, exp_i); chk("st_d_gnt", d_gnt, !exp_i);
            cnt = exp_i ? 0 : (cnt < 15 ? cnt + 1 : cnt);
            step(); m_rvalid = 1; #1;
            chk("st_rv", {i_rvalid, d_rvalid}, {exp_i, !exp_i});
            chk("st_rsp_gnt", {i_gnt, d_gnt}, 0);
            step();
        end
        chk("st_cnt_end", 32'(dut.u_prio.cnt_q), 0);
        idle_inputs();

        // spurious response in IDLE
        m_rvalid = 1; #1;
        chk("sp_rvalid", {i_rvalid, d_rvalid}, 0); chk("sp_m_req", m_req, 0);
        step(); m_rvalid = 0; d_req = 1; d_addr = 32'h300; #1;
        chk("sp_d_gnt", d_gnt, 1);
        // reset while BUSY owned by data; late response must be dropped
        step(); d_req = 0; rst_n = 0; #1;
        chk("rb_d_rvalid", d_rvalid, 0);
        step(); rst_n = 1;
        step(); m_rvalid = 1; d_req = 1; d_addr = 32'h304; #1;
        chk("rb_late_rvalid", d_rvalid, 0); chk("rb_d_gnt", d_gnt, 1);
        step(); d_req = 0; m_rvalid = 1; #1;
        chk("rb_d_rvalid_new", d_rvalid, 1);
        step(); idle_inputs();

        // randomized concurrent traffic against the transaction model
        rst_n = 0; step(); rst_n = 1;
        cnt = 0; ipend = 0; dpend = 0; busy = 0; own_i = 0; lat = 0;
        gnt_i = 0; gnt_d = 0; rv_i = 0; rv_d = 0; ia = 0; da = 0; dw = 0; dwe = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ipend && $urandom_range(0, 2) != 0) begin ipend = 1; ia = $urandom; end
            if (!dpend && $urandom_range(0, 2) != 0) begin
                dpend = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom);
            end
            i_req = ipend; i_addr = ia; d_req = dpend; d_addr = da; d_wdata = dw; d_we = dwe;
            d_be = 4'($urandom); m_rdata = $urandom;
            m_rvalid = busy && lat == 0;
            if (busy && lat != 0) lat--;
            #1;
            exp_i = !busy && ipend && (!dpend || cnt >= 4);
            exp_d = !busy && dpend && !exp_i;
            chk("r_excl", {i_gnt, d_gnt} != 2'b11, 1);
            chk("r_i_gnt", i_gnt, exp_i); chk("r_d_gnt", d_gnt, exp_d);
            chk("r_m_req", m_req, exp_i || exp_d);
            if (exp_d) chk("r_m_addr", m_addr, da);
            chk("r_i_rvalid", i_rvalid, m_rvalid && own_i);
            chk("r_d_rvalid", d_rvalid, m_rvalid && !own_i);
            gnt_i += int'(i_gnt); gnt_d += int'(d_gnt);
            rv_i += int'(i_rvalid); rv_d += int'(d_rvalid);
            if (m_rvalid) busy = 0;
            if (exp_i || exp_d) begin
                busy = 1; own_i = exp_i; lat = $urandom_range(0, 4);
                cnt = exp_i ? 0 : (ipend && cnt < 15 ? cnt + 1 : cnt);
                if (exp_i) ipend = 0; else dpend = 0;
            end
            step();
        end
        i_req = 0; d_req = 0;
        for (int k = 0; k < 6 && busy; k++) begin
            m_rvalid = lat == 0;
            if (lat != 0) lat--;
            #1;
            rv_i += int'(i_rvalid); rv_d += int'(d_rvalid);
            if (m_rvalid) busy = 0;
            step();
        end
        chk("r_i_pairs", rv_i, gnt_i); chk("r_d_pairs", rv_d, gnt_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port.
- Sits between the core and the memory.
- Issues at most one outstanding memory transaction at a time.
- Default priority goes to data; a starvation counter guarantees fetch progress.
- Routes each response back to the requester that owns the transaction.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_STARVE, 4, consecutive lost arbitrations after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid on i_rdata
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledge
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory transaction issue (single-cycle pulse)
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables
- m_rvalid  in  1  memory response (read data or write ack); arrives 1 or more cycles after m_req
- m_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: waiting for m_rvalid.
  - Owner register: NONE, INSTR or DATA.
- IDLE, no request: m_req=0, both gnt=0; stay in IDLE.
- IDLE, any request: winner is chosen combinationally in the same cycle.
  - Winner's gnt=1; m_req=1; m_we/m_addr/m_wdata/m_be driven from the winner.
  - A fetch always drives m_we=0, m_be=all ones, m_wdata=0.
  - Next cycle: state=BUSY, owner=winner.
- Winner selection:
  - Only one requester → it wins.
  - Both requesting → DATA wins, unless starve_cnt ≥ MAX_STARVE, in which case INSTR wins.
- starve_cnt (4 bits, saturating):
  - Increments when i_req=1 and DATA wins an arbitration.
  - Clears to 0 when INSTR wins.
  - Unchanged in all other cycles.
- BUSY:
  - No gnt; m_req=0.
  - When m_rvalid=1: owner's rvalid=1 in the same cycle (combinational); next state IDLE, owner=NONE.
  - Requests seen during BUSY are arbitrated in the first IDLE cycle.
- Timing:
  - Best-case issue-to-response latency is one cycle.
  - Back-to-back throughput is one transaction per two cycles; no issue occurs in the m_rvalid cycle.
- Store response: m_rvalid produces a d_rvalid pulse as the write ack; d_rdata content is don't-care.
- Read data: i_rdata and d_rdata are wired directly to m_rdata; only the rvalid lines qualify them.
- m_rvalid in IDLE is spurious: ignored, and no rvalid is asserted.
- Reset, rst_n=0 at a clock edge:
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All gnt, rvalid and m_req outputs are 0 while rst_n=0.
  - A response pending at reset is dropped; its late m_rvalid is then ignored as spurious.
- Invariants:
  - i_gnt and d_gnt are never both 1.
  - i_rvalid and d_rvalid are never both 1.
  - At most one transaction is outstanding.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum {IDLE, BUSY} arb_state_t
  - typedef enum {OWN_NONE, OWN_INSTR, OWN_DATA} arb_owner_t
  - localparam STARVE_W = 4
- Sub-module mem_arb_prio:
  - Contains the starve_cnt register and the combinational winner logic.
  - Inputs: clk, rst_n, i_req, d_req, arb_en.
  - Outputs: win_instr, win_data.
- Top level holds the FSM, the owner register and the port muxing.

Test Plan:
- Fetch only: i_req=1, i_addr=0x10, d_req=0.
  - Response: i_gnt=1 and m_req=1 with m_addr=0x10, m_we=0 in cycle N.
  - With m_rvalid=1 and m_rdata=0xDEADBEEF in N+1: i_rvalid=1 and i_rdata=0xDEADBEEF in N+1; d_rvalid=0.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678, d_be=4'b0011.
  - Response: m_we=1 with the same addr/wdata/be.
  - m_rvalid two cycles later gives d_rvalid=1 for one cycle; m_req stays low meanwhile.
- Simultaneous requests: i_req=d_req=1 at the first IDLE cycle.
  - Response: d_gnt=1, i_gnt=0.
  - After d_rvalid, the next IDLE cycle gives i_gnt (d_req dropped).
- Starvation: hold i_req=1 and d_req=1 continuously, MAX_STARVE=4, 1-cycle memory.
  - Response: grant sequence D,D,D,D,I,D,D,D,D,I.
  - starve_cnt reads 4 at each INSTR win, then 0.
- Spurious and reset:
  - m_rvalid=1 in IDLE → no rvalid asserted.
  - Reset asserted while BUSY (owner=DATA), then m_rvalid one cycle after reset deasserts → d_rvalid=0, state=IDLE, next request is granted immediately.
- Random concurrent stimulus with latency 1..5, checked by assertions:
  - Grants are mutually exclusive.
  - Every gnt gets exactly one matching rvalid.
  - m_req is never asserted while BUSY.
